// File: rtl/id_ex_pkg.sv
// Shared types for the ID/EX elastic pipeline buffer: control bundle and buffer state.
package id_ex_pkg;

  localparam int CTRL_W = 11;

  typedef struct packed {
    logic       ALUSrc;
    logic       memWrite;
    logic       memRead;
    logic       memToReg;
    logic       regWrite;
    logic [1:0] ALUOp;
    logic [3:0] instructionALUCtr;
  } id_ex_ctrl_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/pipe_payload_reg.sv
// One payload slot of the elastic buffer: a load-enabled register with synchronous clear.
module pipe_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins over load so a reset/flush never lets a same-cycle entry through.
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/buffer_id_ex_elastic.sv
// ID/EX pipeline register as a two-entry skid buffer with flush and a saturating stall counter.
module buffer_id_ex_elastic
  import id_ex_pkg::*;
#(
  parameter int N     = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  id_ex_ctrl_t       ctrl_next,
  input  logic [RA_W-1:0]   writeReg_next,
  input  logic [RA_W-1:0]   readReg1_next,
  input  logic [RA_W-1:0]   readReg2_next,
  input  logic [N*2-1:0]    data1_next,
  input  logic [N*2-1:0]    data2_next,
  input  logic [N*2-1:0]    immGen_next,
  output logic              out_valid,
  input  logic              out_ready,
  output id_ex_ctrl_t       ctrl_actual,
  output logic [RA_W-1:0]   writeReg_actual,
  output logic [RA_W-1:0]   readReg1_actual,
  output logic [RA_W-1:0]   readReg2_actual,
  output logic [N*2-1:0]    data1_actual,
  output logic [N*2-1:0]    data2_actual,
  output logic [N*2-1:0]    immGen_actual,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PW = CTRL_W + 3 * RA_W + 6 * N;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  buf_state_t    state;
  logic          accept;
  logic          consume;
  logic          main_load;
  logic          main_clr;
  logic          main_from_skid;
  logic          skid_load;
  logic          skid_clr;
  logic [PW-1:0] in_payload;
  logic [PW-1:0] main_d;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  assign in_payload = {ctrl_next, writeReg_next, readReg1_next, readReg2_next,
                       data1_next, data2_next, immGen_next};
  assign main_d = main_from_skid ? skid_q : in_payload;

  // Main is cleared whenever the buffer goes empty, so a bubble always shows zero control.
  assign {ctrl_actual, writeReg_actual, readReg1_actual, readReg2_actual,
          data1_actual, data2_actual, immGen_actual} = main_q;

  always_comb begin
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (rst || flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        EMPTY: main_load = accept;
        HALF: begin
          if (accept && consume)       main_load = 1'b1;
          else if (accept)             skid_load = 1'b1;
          else if (consume)            main_clr  = 1'b1;
        end
        FULL: begin
          if (consume) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  // Handshake flags are registered alongside the state so in_ready never sees out_ready.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= HALF;
            out_valid <= 1'b1;
          end
        end
        HALF: begin
          if (accept && !consume) begin
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (consume && !accept) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (consume) begin
            state    <= HALF;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  pipe_payload_reg #(.W(PW)) u_main (
    .clk   (clk),
    .clear (main_clr),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_payload_reg #(.W(PW)) u_skid (
    .clk   (clk),
    .clear (skid_clr),
    .load  (skid_load),
    .d     (in_payload),
    .q     (skid_q)
  );

endmodule
